// File: rtl/goldschmidt_div_seq.sv
// Sequential Goldschmidt divider sharing one WIDTHxWIDTH multiplier between the N and D streams.
// Define GDIV_INEXACT_EN to add the registered `inexact` output flag.
module goldschmidt_div_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] ia,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
`ifdef GDIV_INEXACT_EN
  output logic             inexact,
`endif
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MN   = 3'd1;
  localparam logic [2:0] MD   = 3'd2;
  localparam logic [2:0] RND  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int CW = $clog2(ITER + 1);

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   n_q, d_q, k_q;
  logic [2*WIDTH-1:0] p_q;

  // Rounding of the current product back to Q1.(WIDTH-1), saturating on overflow.
  logic [WIDTH-1:0] keep, rounded, rne_val, k_next, kk, mul_a, mul_b;
  logic             guard, sticky, round_up, carry, rne_sat;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    keep     = p_q[2*WIDTH-2:WIDTH-1];
    guard    = p_q[WIDTH-2];
    sticky   = |p_q[WIDTH-3:0];
    round_up = guard & (sticky | keep[0]);
    {carry, rounded} = {1'b0, keep} + {{WIDTH{1'b0}}, round_up};
    rne_sat  = p_q[2*WIDTH-1] | carry;
    rne_val  = rne_sat ? {WIDTH{1'b1}} : rounded;
    k_next   = (~rne_val) + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // The first MN uses the seed; later MNs use K = 2 - D taken straight from the fresh D product.
  always_comb begin
    kk      = (cnt == '0) ? k_q : k_next;
    mul_a   = (state == MN) ? n_q : d_q;
    mul_b   = (state == MN) ? kk : k_q;
    product = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
  end

`ifdef GDIV_INEXACT_EN
  logic lost;
  always_comb lost = guard | sticky | rne_sat;
`endif

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/result/div_zero hold steady until that transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      n_q       <= '0;
      d_q       <= '0;
      k_q       <= '0;
      p_q       <= '0;
      result    <= '0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
`ifdef GDIV_INEXACT_EN
      inexact   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_q <= n;
            d_q <= d;
            k_q <= ia;
            cnt <= '0;
            if (d == '0) begin
              result    <= {WIDTH{1'b1}};
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
`ifdef GDIV_INEXACT_EN
              inexact   <= 1'b0;
`endif
              state     <= DONE;
            end else begin
              state <= MN;
            end
          end
        end
        MN: begin
          p_q <= product;
          if (cnt != '0) begin
            d_q <= rne_val;
            k_q <= k_next;
          end
          state <= (cnt == CW'(ITER - 1)) ? RND : MD;
        end
        MD: begin
          n_q   <= rne_val;
          p_q   <= product;
          cnt   <= cnt + 1'b1;
          state <= MN;
        end
        RND: begin
          result    <= rne_val;
          div_zero  <= 1'b0;
          out_valid <= 1'b1;
`ifdef GDIV_INEXACT_EN
          inexact   <= lost;
`endif
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Directed bench for goldschmidt_div_seq: an ITER=4 and an ITER=1 instance, hand-computed vectors.
module tb_goldschmidt_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv4, iv1, out_ready, sel;
  logic [15:0] n_in, d_in, ia_in;
  logic        ir4, ov4, dz4, ir1, ov1, dz1;
  logic [15:0] res4, res1;
  logic [2:0]  sd4, sd1;
  logic        ir, ov, dz;
  logic [15:0] res;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

`ifdef GDIV_INEXACT_EN
  logic inx4, inx1, inx;
  assign inx = sel ? inx1 : inx4;
`endif

  goldschmidt_div_seq #(.WIDTH(16), .ITER(4)) dut4 (
    .clk(clk), .reset(rst_n), .in_valid(iv4), .in_ready(ir4),
    .n(n_in), .d(d_in), .ia(ia_in), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .div_zero(dz4),
`ifdef GDIV_INEXACT_EN
    .inexact(inx4),
`endif
    .state_dbg(sd4)
  );

  goldschmidt_div_seq #(.WIDTH(16), .ITER(1)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(iv1), .in_ready(ir1),
    .n(n_in), .d(d_in), .ia(ia_in), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .div_zero(dz1),
`ifdef GDIV_INEXACT_EN
    .inexact(inx1),
`endif
    .state_dbg(sd1)
  );

  assign ir  = sel ? ir1  : ir4;
  assign ov  = sel ? ov1  : ov4;
  assign dz  = sel ? dz1  : dz4;
  assign res = sel ? res1 : res4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // lat counts edges after the accepting edge until out_valid is seen (0 = visible right after it).
  task automatic do_op(input logic use1, input logic [15:0] nv, input logic [15:0] dv,
                       input logic [15:0] iav, input logic [15:0] er, input logic edz,
                       input int elat, input logic einx, input string tag);
    int lat;
    sel = use1; n_in = nv; d_in = dv; ia_in = iav;
    if (use1) iv1 = 1'b1; else iv4 = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv4 = 1'b0; iv1 = 1'b0;
    lat = -1;
    if (ov) lat = 0;
    else begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (ov) begin lat = c; break; end
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " result"}, 32'(res), 32'(er));
    check({tag, " div_zero"}, 32'(dz), 32'(edz));
`ifdef GDIV_INEXACT_EN
    check({tag, " inexact"}, 32'(inx), 32'(einx));
`else
    if (einx === 1'bx) $display("unreachable");
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(ov), 32'd0);
    check({tag, " in_ready back"}, 32'(ir), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; iv4 = 1'b0; iv1 = 1'b0; out_ready = 1'b0; sel = 1'b0;
    n_in = '0; d_in = '0; ia_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(ir4), 32'd1);
    check("reset out_valid", 32'(ov4), 32'd0);
    check("reset result", 32'(res4), 32'd0);
    check("reset div_zero", 32'(dz4), 32'd0);
    check("reset state", 32'(sd4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ITER=4 vectors
    do_op(1'b0, 16'hA000, 16'h8000, 16'h8000, 16'hA000, 1'b0, 8, 1'b0, "exact4");
    do_op(1'b0, 16'hC000, 16'hC000, 16'h5555, 16'h8000, 1'b0, 8, 1'b0, "conv_1p5");
    do_op(1'b0, 16'h8000, 16'hC000, 16'h5555, 16'h5555, 1'b0, 8, 1'b0, "conv_third");
    do_op(1'b0, 16'h8000, 16'hA000, 16'h6000, 16'h6666, 1'b0, 8, 1'b0, "conv_0p8");
    do_op(1'b0, 16'h9000, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0, 1'b0, "divzero");
    do_op(1'b0, 16'hFFFF, 16'h8000, 16'h7000, 16'hFFFF, 1'b0, 8, 1'b1, "sat_under");

    // ITER=1 vectors: single multiply by the seed then round
    do_op(1'b1, 16'hA000, 16'h8000, 16'h8000, 16'hA000, 1'b0, 2, 1'b0, "exact1");
    do_op(1'b1, 16'hFFFE, 16'h8000, 16'h8001, 16'hFFFF, 1'b0, 2, 1'b1, "round_carry_sat");
    do_op(1'b1, 16'hFFFF, 16'h8000, 16'h9000, 16'hFFFF, 1'b0, 2, 1'b1, "msb_sat");
    do_op(1'b1, 16'h8001, 16'h8000, 16'h4000, 16'h4000, 1'b0, 2, 1'b1, "tie_even_down");
    do_op(1'b1, 16'h8003, 16'h8000, 16'h4000, 16'h4002, 1'b0, 2, 1'b1, "tie_odd_up");

    // Backpressure: result holds, busy input pulses are ignored
    sel = 1'b0; n_in = 16'h8000; d_in = 16'hA000; ia_in = 16'h6000; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov4) begin lat = c; break; end
    end
    check("bp latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      n_in = 16'h1111 * 16'(k + 1); d_in = 16'h8000; ia_in = 16'h8000; iv4 = 1'b1;
      @(posedge clk); #1;
      check("bp result hold", 32'(res4), 32'h6666);
      check("bp out_valid hold", 32'(ov4), 32'd1);
      check("bp in_ready low", 32'(ir4), 32'd0);
    end
    iv4 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp in_ready after accept", 32'(ir4), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp nothing latched", 32'(sd4), 32'd0);

    // Reset while in MD1 (third edge after accept)
    sel = 1'b0; n_in = 16'hA000; d_in = 16'h8000; ia_in = 16'h8000; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midop in MD", 32'(sd4), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midop out_valid", 32'(ov4), 32'd0);
    check("midop in_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 16'h8000, 16'hA000, 16'h6000, 16'h6666, 1'b0, 8, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
